// File: rtl/pipe_collision_scanner.sv
// Time-multiplexed bird/pipe collision scanner: floor/ceiling in one cycle, then one pipe per cycle.
// Also keeps per-pipe "passed" flags that drive a saturating score.
module pipe_collision_scanner #(
  parameter int NUM_PIPES   = 4,
  parameter int COORD_W     = 32,
  parameter int BIRD_SIZE_X = 34,
  parameter int BIRD_SIZE_Y = 24,
  parameter int PIPE_SIZE_X = 78,
  parameter int PIPE_GAP    = 60,
  parameter int PAD_X       = 6,
  parameter int PAD_Y       = 3,
  parameter int FLOOR_Y     = 418,
  parameter int SCREEN_H    = 480,
  parameter int CEIL_EN     = 1,
  parameter int SCORE_W     = 8,
  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           clear,
  input  logic signed [COORD_W-1:0]      birdX,
  input  logic signed [COORD_W-1:0]      birdY,
  input  logic [COORD_W*NUM_PIPES-1:0]   pipeX_flat,
  input  logic [COORD_W*NUM_PIPES-1:0]   pipeY_flat,
  output logic                           busy,
  output logic                           done,
  output logic                           collision,
  output logic                           frame_hit,
  output logic [1:0]                     hit_type,
  output logic [IW-1:0]                  hit_index,
  output logic [SCORE_W-1:0]             score,
  output logic [1:0]                     dbg_state
);
  // Handshake: start is a level sampled only in IDLE (never queued); done is a one-cycle
  // pulse in the cycle the new results first appear; clear overrides start in the same cycle.

  localparam int EW = COORD_W + 2;
  localparam logic signed [EW-1:0] K_BSX   = EW'(BIRD_SIZE_X);
  localparam logic signed [EW-1:0] K_BSY   = EW'(BIRD_SIZE_Y);
  localparam logic signed [EW-1:0] K_PSX   = EW'(PIPE_SIZE_X);
  localparam logic signed [EW-1:0] K_GAP   = EW'(PIPE_GAP);
  localparam logic signed [EW-1:0] K_PADX  = EW'(PAD_X);
  localparam logic signed [EW-1:0] K_PADY  = EW'(PAD_Y);
  localparam logic signed [EW-1:0] K_FLOOR = EW'(FLOOR_Y);
  localparam logic signed [EW-1:0] K_SCRH  = EW'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_BOUND, S_SCAN, S_DONE} state_t;
  state_t r_state, w_next;

  logic signed [COORD_W-1:0] r_bx, r_by;
  logic signed [COORD_W-1:0] r_px [NUM_PIPES];
  logic signed [COORD_W-1:0] r_py [NUM_PIPES];
  logic [IW-1:0]             r_idx;
  logic [1:0]                r_ht;
  logic [IW-1:0]             r_hi;
  logic [NUM_PIPES-1:0]      r_passed;
  logic                      r_collision, r_frame_hit;
  logic [1:0]                r_hit_type;
  logic [IW-1:0]             r_hit_index;
  logic [SCORE_W-1:0]        r_score;

  logic signed [EW-1:0] w_bx, w_by, w_px, w_py;
  logic w_floor, w_ceil, w_xov, w_yhit, w_phit, w_pass, w_rearm, w_last;
  logic [1:0]    w_ht_next;
  logic [IW-1:0] w_hi_next;

  assign w_bx = EW'(r_bx);
  assign w_by = EW'(r_by);
  assign w_px = EW'(r_px[r_idx]);
  assign w_py = EW'(r_py[r_idx]);

  assign w_floor = (w_by + K_BSY >= K_FLOOR) && (w_by + K_BSY <= K_SCRH);
  assign w_ceil  = (CEIL_EN != 0) && w_by[EW-1];
  assign w_xov   = (w_bx + K_BSX - K_PADX >= w_px) && (w_bx + K_PADX <= w_px + K_PSX);
  assign w_yhit  = (w_by + K_BSY - K_PADY >= w_py + K_GAP) || (w_by + K_PADY <= w_py - K_GAP);
  assign w_phit  = w_xov && w_yhit;
  assign w_pass  = (w_bx + K_PADX > w_px + K_PSX);
  assign w_rearm = (w_px > w_bx + K_BSX);
  assign w_last  = (r_idx == IW'(NUM_PIPES - 1));

  // Any earlier hit (floor, ceiling or a lower-index pipe) blocks recording this pipe.
  assign w_ht_next = (r_ht == 2'd0 && w_phit) ? 2'd3 : r_ht;
  assign w_hi_next = (r_ht == 2'd0 && w_phit) ? r_idx : r_hi;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BOUND;
      S_BOUND: w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bx <= '0; r_by <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
      r_idx <= '0; r_ht <= '0; r_hi <= '0; r_passed <= '0;
      r_collision <= 1'b0; r_frame_hit <= 1'b0;
      r_hit_type <= '0; r_hit_index <= '0; r_score <= '0;
    end else if (clear) begin
      r_idx <= '0; r_ht <= '0; r_hi <= '0; r_passed <= '0;
      r_collision <= 1'b0; r_frame_hit <= 1'b0;
      r_hit_type <= '0; r_hit_index <= '0; r_score <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_bx <= birdX;
          r_by <= birdY;
          for (int i = 0; i < NUM_PIPES; i++) begin
            r_px[i] <= pipeX_flat[COORD_W*i +: COORD_W];
            r_py[i] <= pipeY_flat[COORD_W*i +: COORD_W];
          end
        end
        S_BOUND: begin
          r_idx <= '0;
          r_hi  <= '0;
          r_ht  <= w_floor ? 2'd1 : (w_ceil ? 2'd2 : 2'd0);
        end
        S_SCAN: begin
          r_ht  <= w_ht_next;
          r_hi  <= w_hi_next;
          r_idx <= r_idx + IW'(1);
          if (w_pass && !r_passed[r_idx]) begin
            r_passed[r_idx] <= 1'b1;
            if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          end else if (w_rearm) begin
            r_passed[r_idx] <= 1'b0;
          end
          // Results land on the edge into DONE so they are visible with the done pulse.
          if (w_last) begin
            r_frame_hit <= (w_ht_next != 2'd0);
            r_hit_type  <= w_ht_next;
            r_hit_index <= w_hi_next;
            r_collision <= r_collision | (w_ht_next != 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == S_BOUND) || (r_state == S_SCAN);
  assign done      = (r_state == S_DONE);
  assign collision = r_collision;
  assign frame_hit = r_frame_hit;
  assign hit_type  = r_hit_type;
  assign hit_index = r_hit_index;
  assign score     = r_score;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_pipe_collision_scanner.sv
// Directed bench for pipe_collision_scanner with three pipes; a second instance has the ceiling disabled.
module tb_pipe_collision_scanner;
  localparam int NP = 3;
  localparam int CW = 32;

  logic clk, reset_n, start, clear;
  logic signed [CW-1:0] birdX, birdY;
  logic [CW*NP-1:0] pipeX_flat, pipeY_flat;
  logic busy, done, collision, frame_hit;
  logic [1:0] hit_type, dbg_state;
  logic [1:0] hit_index;
  logic [7:0] score;
  logic busy_nc, done_nc, collision_nc, frame_hit_nc;
  logic [1:0] hit_type_nc, dbg_state_nc, hit_index_nc;
  logic [7:0] score_nc;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_collision_scanner #(.NUM_PIPES(NP)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .birdX(birdX), .birdY(birdY), .pipeX_flat(pipeX_flat), .pipeY_flat(pipeY_flat),
    .busy(busy), .done(done), .collision(collision), .frame_hit(frame_hit),
    .hit_type(hit_type), .hit_index(hit_index), .score(score), .dbg_state(dbg_state)
  );

  pipe_collision_scanner #(.NUM_PIPES(NP), .CEIL_EN(0)) u_dut_nc (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .birdX(birdX), .birdY(birdY), .pipeX_flat(pipeX_flat), .pipeY_flat(pipeY_flat),
    .busy(busy_nc), .done(done_nc), .collision(collision_nc), .frame_hit(frame_hit_nc),
    .hit_type(hit_type_nc), .hit_index(hit_index_nc), .score(score_nc), .dbg_state(dbg_state_nc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_pipe(input int i, input int x, input int y);
    pipeX_flat[CW*i +: CW] = x;
    pipeY_flat[CW*i +: CW] = y;
  endtask

  task automatic park_all();
    for (int i = 0; i < NP; i++) set_pipe(i, 640, 240);
  endtask

  task automatic set_bird(input int x, input int y);
    birdX = x;
    birdY = y;
  endtask

  // Returns the cycle (counted from the start edge) at which done was seen; 20 = timeout.
  task automatic run_scan(output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; clear = 1'b0;
    set_bird(100, 200); park_all();
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, collision, frame_hit} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, collision, frame_hit}); end
    n_cmp++; if ({hit_type, hit_index, score} !== 12'd0) begin n_fail++;
      $display("FAIL reset_results: got type=%0d idx=%0d score=%0d expected 0/0/0", hit_type, hit_index, score); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
  endtask

  task automatic test_timing_floor();
    int lat;
    set_bird(100, 394); park_all();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (busy !== (k <= 4) || done !== (k == 5)) begin n_fail++;
        $display("FAIL timing_k%0d: got busy=%b done=%b expected busy=%b done=%b", k, busy, done, (k <= 4), (k == 5)); end
      if (k == 5) begin
        n_cmp++; if ({frame_hit, hit_type, collision} !== 4'b1011) begin n_fail++;
          $display("FAIL floor_hit: got fh=%b type=%0d col=%b expected 1/1/1", frame_hit, hit_type, collision); end
      end
      @(negedge clk);
    end
    set_bird(100, 200);
    run_scan(lat);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL floor_clear_lat: got %0d expected 5", lat); end
    n_cmp++; if ({frame_hit, hit_type, collision} !== 4'b0001) begin n_fail++;
      $display("FAIL floor_sticky: got fh=%b type=%0d col=%b expected 0/0/1", frame_hit, hit_type, collision); end
  endtask

  task automatic test_pipe();
    int lat;
    set_bird(100, 200); park_all();
    set_pipe(1, 120, 150); set_pipe(2, 110, 150);
    run_scan(lat);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL pipe_lat: got %0d expected 5", lat); end
    n_cmp++; if ({frame_hit, hit_type, hit_index} !== 5'b1_11_01) begin n_fail++;
      $display("FAIL pipe_hit: got fh=%b type=%0d idx=%0d expected 1/3/1", frame_hit, hit_type, hit_index); end
    park_all(); set_pipe(1, 120, 240);
    run_scan(lat);
    n_cmp++; if ({frame_hit, hit_type, hit_index} !== 5'b0_00_00) begin n_fail++;
      $display("FAIL pipe_miss: got fh=%b type=%0d idx=%0d expected 0/0/0", frame_hit, hit_type, hit_index); end
  endtask

  task automatic test_score();
    int lat;
    do_clear();
    n_cmp++; if ({collision, score} !== 9'd0) begin n_fail++;
      $display("FAIL score_clear: got col=%b score=%0d expected 0/0", collision, score); end
    set_bird(100, 200); park_all(); set_pipe(0, 10, 240);
    run_scan(lat);
    n_cmp++; if (score !== 8'd1) begin n_fail++; $display("FAIL score_pass: got %0d expected 1", score); end
    run_scan(lat);
    n_cmp++; if (score !== 8'd1) begin n_fail++; $display("FAIL score_rescan: got %0d expected 1", score); end
    set_pipe(0, 640, 240); run_scan(lat);
    set_pipe(0, 10, 240);  run_scan(lat);
    n_cmp++; if (score !== 8'd2) begin n_fail++; $display("FAIL score_rearm: got %0d expected 2", score); end
    n_cmp++; if (collision !== 1'b0) begin n_fail++; $display("FAIL score_nohit: got col=%b expected 0", collision); end
  endtask

  task automatic test_saturate();
    int lat;
    do_clear();
    set_bird(100, 200);
    for (int r = 0; r < 86; r++) begin
      for (int i = 0; i < NP; i++) set_pipe(i, 10, 240);
      run_scan(lat);
      if (r == 83) begin
        n_cmp++; if (score !== 8'd252) begin n_fail++; $display("FAIL sat_252: got %0d expected 252", score); end
      end
      if (r == 84) begin
        n_cmp++; if (score !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", score); end
      end
      park_all();
      run_scan(lat);
    end
    n_cmp++; if (score !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", score); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL sat_lat: got %0d expected 5", lat); end
  endtask

  task automatic test_ceiling();
    int lat;
    set_bird(100, -5); park_all();
    run_scan(lat);
    n_cmp++; if ({frame_hit, hit_type} !== 3'b1_10) begin n_fail++;
      $display("FAIL ceil_on: got fh=%b type=%0d expected 1/2", frame_hit, hit_type); end
    n_cmp++; if ({frame_hit_nc, hit_type_nc, collision_nc} !== 4'b0_00_0) begin n_fail++;
      $display("FAIL ceil_off: got fh=%b type=%0d col=%b expected 0/0/0", frame_hit_nc, hit_type_nc, collision_nc); end
  endtask

  task automatic test_control();
    int dcount;
    int lat;
    // start pulses while busy are ignored
    set_bird(100, 200); park_all();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 2 || k == 3);
      if (done) dcount++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++; if (dcount !== 1) begin n_fail++; $display("FAIL busy_start: got %0d dones expected 1", dcount); end

    // clear mid-scan
    set_bird(100, 394);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    n_cmp++; if (dcount !== 0) begin n_fail++; $display("FAIL clear_done: got %0d dones expected 0", dcount); end
    n_cmp++; if ({busy, collision, frame_hit, hit_type, hit_index, score} !== 15'd0) begin n_fail++;
      $display("FAIL clear_outs: got busy=%b col=%b fh=%b type=%0d idx=%0d score=%0d expected all 0",
               busy, collision, frame_hit, hit_type, hit_index, score); end

    // reset mid-scan, then a normal scan
    set_bird(100, 394);
    run_scan(lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, collision, frame_hit, hit_type, dbg_state} !== 8'd0) begin n_fail++;
      $display("FAIL rst_mid: got busy=%b done=%b col=%b fh=%b type=%0d st=%0d expected all 0",
               busy, done, collision, frame_hit, hit_type, dbg_state); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_bird(100, 200);
    run_scan(lat);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL rst_rescan_lat: got %0d expected 5", lat); end
    n_cmp++; if ({frame_hit, hit_type, collision} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_rescan: got fh=%b type=%0d col=%b expected 0/0/0", frame_hit, hit_type, collision); end
  endtask

  initial begin
    test_reset();
    test_timing_floor();
    test_pipe();
    test_score();
    test_saturate();
    test_ceiling();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_collision_scanner.md
# pipe_collision_scanner

Time-multiplexed successor to the per-frame collision check: on a frame `start` strobe it snapshots bird and pipe coordinates, tests floor/ceiling and then one pipe per clock, and reports a sticky collision flag, the lowest-index pipe hit and a done pulse. It also tracks per-pipe "passed" state to produce a saturating score. It sits between the game-state FSM (start/clear, reads results) and the pipe/bird position generators.

## Interface
- `NUM_PIPES`, 4: pipes scanned, ≥1.
- `COORD_W`, 32: signed coordinate width.
- `BIRD_SIZE_X`, 34: bird sprite width.
- `BIRD_SIZE_Y`, 24: bird sprite height.
- `PIPE_SIZE_X`, 78: pipe width.
- `PIPE_GAP`, 60: half-gap about `pipeY`.
- `PAD_X`, 6 / `PAD_Y`, 3: hitbox inset for sprite padding.
- `FLOOR_Y`, 418 / `SCREEN_H`, 480: floor band.
- `CEIL_EN`, 1: 1 = `birdY < 0` counts as a hit.
- `SCORE_W`, 8: score counter width.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin scan; honoured only in IDLE.
- `clear` in 1: new game; clears collision, score and passed bits; aborts any scan.
- `birdX`, `birdY` in COORD_W each: signed bird top-left.
- `pipeX_flat`, `pipeY_flat` in COORD_W*NUM_PIPES each: pipe i at bits [COORD_W*(i+1)-1 -: COORD_W].
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse, results valid.
- `collision` out 1: sticky; set by any hit, cleared only by `clear`/reset.
- `frame_hit` out 1: hit in the most recent completed scan.
- `hit_type` out 2: 0 none, 1 floor, 2 ceiling, 3 pipe (most recent scan).
- `hit_index` out clog2(NUM_PIPES) (min 1): lowest pipe hit; 0 if none.
- `score` out SCORE_W: pipes passed, saturates at all-ones.

## Operation
- States: IDLE → BOUND → SCAN → DONE → IDLE.
- IDLE: `start` high → register snapshot of all coordinate inputs, go to BOUND. Inputs are not sampled again until the next start.
- BOUND: floor hit if `birdY+BIRD_SIZE_Y >= FLOOR_Y` and `<= SCREEN_H`; ceiling hit if `CEIL_EN` and `birdY < 0`. Floor takes priority over ceiling. Index counter := 0.
- SCAN, one pipe per cycle, index i:
  - X overlap: `birdX+BIRD_SIZE_X-PAD_X >= pipeX[i]` and `birdX+PAD_X <= pipeX[i]+PIPE_SIZE_X`.
  - Y hit: `birdY+BIRD_SIZE_Y-PAD_Y >= pipeY[i]+PIPE_GAP` or `birdY+PAD_Y <= pipeY[i]-PIPE_GAP`.
  - Pipe hit = X overlap and Y hit. The first pipe hit records `hit_index`. A pipe hit is recorded only if no floor or ceiling hit was recorded; floor and ceiling take precedence over pipes in `hit_type`.
  - Passed: if `birdX+PAD_X > pipeX[i]+PIPE_SIZE_X` and `passed[i]==0`, set `passed[i]` and increment `score` (saturating). If `pipeX[i] > birdX+BIRD_SIZE_X`, clear `passed[i]` (respawn re-arm).
  - Leave SCAN after i = NUM_PIPES-1.
- DONE: pulse `done`; update `frame_hit`, `hit_type` and `hit_index`; `collision |= frame_hit`; return to IDLE.
- Arithmetic: all comparisons signed, evaluated at COORD_W+2 bits so that sums and differences cannot overflow.
- `clear` has priority over everything. It takes effect in any state, returns the FSM to IDLE with no `done` pulse, and zeros `collision`, `frame_hit`, `hit_type`, `hit_index`, `score` and `passed`. `start` in the same cycle as `clear` is ignored.
- `start` while busy is ignored and is not queued.

## Timing
- Reset (async assert, sync deassert handled upstream): all outputs 0, FSM IDLE, `passed` all 0.
- `start` sampled at edge T → `busy`=1 in cycles T+1 … T+NUM_PIPES+1 (BOUND at T+1, pipe i at T+2+i).
- `done`=1 and new results visible in cycle T+NUM_PIPES+2. `busy`=0 in that cycle. `score` increments are visible one cycle after the corresponding SCAN cycle.
- Back-to-back: a `start` held high during the DONE cycle is accepted at the next IDLE edge. Minimum period between scans is NUM_PIPES+3 cycles.
- `reset_n` low mid-scan: immediate return to reset values; no `done`.

## Test plan
Setup for all scenarios: NUM_PIPES=3; all pipes parked at X=640, Y=240 unless stated.
- Floor: birdX=100, birdY=394 → `done` at T+5, `frame_hit`=1, `hit_type`=1, `collision`=1. Then birdY=200 scan → `frame_hit`=0, `collision` stays 1.
- Pipe: bird (100,200); pipe1=(120,150), pipe2=(110,150) → `hit_type`=3, `hit_index`=1. Same bird with pipe1=(120,240) and pipe2 parked → no hit, `hit_type`=0.
- Score: bird (100,200), pipe0 X=10 → `score`=1. Rescan unchanged → `score`=1. Pipe0 X=640 scan, then X=10 scan → `score`=2. Preload 255 with SCORE_W=8 → saturates at 255.
- Ceiling: birdY=-5 with CEIL_EN=1 → `hit_type`=2. With CEIL_EN=0 → no hit.
- Control: `start` pulses during busy are ignored (exactly one `done`); `clear` at T+3 → no `done`, all outputs 0; `reset_n` low at T+2 → outputs 0, next `start` scans normally.
